// File: rtl/counter_pkg.sv
`default_nettype none
// ============================================================
// Module : counter_pkg
// Brief  : Shared mode encodings for the windowed up/down counter
// Rev    : 1.0
// ============================================================
package counter_pkg;

  typedef enum logic [1:0] {
    MODE_UP      = 2'd0,
    MODE_DOWN    = 2'd1,
    MODE_BOUNCE  = 2'd2,
    MODE_ONESHOT = 2'd3
  } mode_e;

endpackage
`default_nettype wire

// File: rtl/counter_step.sv
`default_nettype none
// ============================================================
// Module : counter_step
// Brief  : Next-state function for one enabled counting edge
// Rev    : 1.0
// ============================================================
module counter_step
  import counter_pkg::*;
#(
  parameter int WIDTH = 3
) (
  input  logic [WIDTH-1:0] counter,
  input  logic             dir,
  input  logic             done,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] lo,
  input  logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] counter_nxt,
  output logic             dir_nxt,
  output logic             turn,
  output logic             done_nxt
);

  localparam logic [WIDTH-1:0] c_one = {{(WIDTH-1){1'b0}}, 1'b1};

  logic out_of_window;
  assign out_of_window = (counter < lo) || (counter > hi);

  always_comb begin
    counter_nxt = counter;
    dir_nxt     = dir;
    turn        = 1'b0;
    done_nxt    = done;

    case (mode_e'(mode))
      MODE_UP: begin
        dir_nxt = 1'b1;
        if (out_of_window) begin
          counter_nxt = lo;
        end else if (counter == hi) begin
          counter_nxt = lo;
          turn        = 1'b1;
        end else begin
          counter_nxt = counter + c_one;
        end
      end

      MODE_DOWN: begin
        dir_nxt = 1'b0;
        if (out_of_window) begin
          counter_nxt = hi;
        end else if (counter == lo) begin
          counter_nxt = hi;
          turn        = 1'b1;
        end else begin
          counter_nxt = counter - c_one;
        end
      end

      MODE_BOUNCE: begin
        if (out_of_window) begin
          counter_nxt = lo;
          dir_nxt     = 1'b1;
        end else if (lo == hi) begin
          // Degenerate window: value is pinned, only the direction flips.
          dir_nxt = ~dir;
          turn    = 1'b1;
        end else if (dir) begin
          if (counter == hi) begin
            dir_nxt     = 1'b0;
            counter_nxt = hi - c_one;
            turn        = 1'b1;
          end else begin
            counter_nxt = counter + c_one;
          end
        end else begin
          if (counter == lo) begin
            dir_nxt     = 1'b1;
            counter_nxt = lo + c_one;
            turn        = 1'b1;
          end else begin
            counter_nxt = counter - c_one;
          end
        end
      end

      MODE_ONESHOT: begin
        if (done) begin
          counter_nxt = hi;
        end else if (out_of_window) begin
          counter_nxt = lo;
        end else begin
          if (counter != hi) begin
            counter_nxt = counter + c_one;
          end
          if (counter_nxt == hi) begin
            done_nxt = 1'b1;
            turn     = 1'b1;
          end
        end
      end

      default: ;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/counter_updown_param.sv
`default_nettype none
// ============================================================
// Module : counter_updown_param
// Brief  : Windowed up/down/bounce/one-shot counter with preload
// Rev    : 1.0
// ============================================================
module counter_updown_param
  import counter_pkg::*;
#(
  parameter int               WIDTH   = 3,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] lo,
  input  logic [WIDTH-1:0] hi,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] counter,
  output logic             dir,
  output logic             turn,
  output logic             done,
  output logic             cfg_err
);

  logic [WIDTH-1:0] counter_q, counter_d;
  logic             dir_q, dir_d;
  logic             turn_q, turn_d;
  logic             done_q, done_d;

  logic [WIDTH-1:0] step_counter;
  logic             step_dir;
  logic             step_turn;
  logic             step_done;

  assign cfg_err = (lo > hi);

  counter_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .counter     (counter_q),
    .dir         (dir_q),
    .done        (done_q),
    .mode        (mode),
    .lo          (lo),
    .hi          (hi),
    .counter_nxt (step_counter),
    .dir_nxt     (step_dir),
    .turn        (step_turn),
    .done_nxt    (step_done)
  );

  // Priority below clr: load, then bad window, then enable, then count.
  always_comb begin
    counter_d = counter_q;
    dir_d     = dir_q;
    turn_d    = 1'b0;
    done_d    = done_q;

    if (load) begin
      counter_d = load_val;
      done_d    = 1'b0;
      if (mode_e'(mode) == MODE_DOWN) begin
        dir_d = 1'b0;
      end
    end else if (!cfg_err && en) begin
      counter_d = step_counter;
      dir_d     = step_dir;
      turn_d    = step_turn;
      done_d    = step_done;
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      counter_q <= RST_VAL;
      dir_q     <= 1'b1;
      turn_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      counter_q <= counter_d;
      dir_q     <= dir_d;
      turn_q    <= turn_d;
      done_q    <= done_d;
    end
  end

  assign counter = counter_q;
  assign dir     = dir_q;
  assign turn    = turn_q;
  assign done    = done_q;

endmodule
`default_nettype wire
